// File: rtl/fetch_queue.sv
// In-order instruction prefetch queue between fetch and decode.
// It issues PC requests to memory, buffers the returned words and squashes in-flight work on redirect.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pc_valid,
    input  logic [AW-1:0] i_pc,
    output logic          o_pc_ready,
    output logic          o_mem_req_valid,
    output logic [AW-1:0] o_mem_req_addr,
    input  logic          i_mem_req_ready,
    input  logic          i_mem_rsp_valid,
    input  logic [DW-1:0] i_mem_rsp_data,
    output logic          o_inst_valid,
    output logic [DW-1:0] o_inst,
    output logic [AW-1:0] o_inst_pc,
    input  logic          i_inst_ready,
    input  logic          i_flush
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] ONE = PW'(1);
    localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] filled;

    logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr, drop;
    logic [PW-1:0] used, inflight, flush_base, flush_drop;
    logic [PW:0]   occupancy;
    logic [IW-1:0] alloc_idx, fill_idx, head_idx;
    logic          credit_ok, do_alloc, do_fill, do_drop, do_pop;

    assign used      = alloc_ptr - head_ptr;
    assign inflight  = alloc_ptr - fill_ptr;
    assign alloc_idx = alloc_ptr[IW-1:0];
    assign fill_idx  = fill_ptr[IW-1:0];
    assign head_idx  = head_ptr[IW-1:0];

    // Stale responses still owed by memory occupy credit; a pop this cycle frees nothing until next cycle.
    assign occupancy = {1'b0, used} + {1'b0, drop};
    assign credit_ok = occupancy < DEPTH_W;

    // Every channel transfers on a cycle where valid and ready are both high; a request is not withdrawn
    // once offered. The response channel has no ready, and flush masks the request and output channels.
    assign o_mem_req_valid = i_pc_valid & credit_ok & ~i_flush;
    assign o_mem_req_addr  = i_pc;
    assign o_pc_ready      = i_mem_req_ready & credit_ok & ~i_flush;

    assign do_alloc = o_mem_req_valid & i_mem_req_ready;
    assign do_drop  = i_mem_rsp_valid & (drop != '0);
    assign do_fill  = i_mem_rsp_valid & (drop == '0) & (inflight != '0);

    assign o_inst_valid = (used != '0) & filled[head_idx] & ~i_flush;
    assign o_inst       = data_mem[head_idx];
    assign o_inst_pc    = pc_mem[head_idx];
    assign do_pop       = o_inst_valid & i_inst_ready;

    // The sum never exceeds DEPTH. A response in the flush cycle is subtracted only when something is owed.
    assign flush_base = drop + inflight;
    assign flush_drop = flush_base - {{(PW-1){1'b0}}, (i_mem_rsp_valid && (flush_base != '0))};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop      <= '0;
            filled    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (i_flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            filled    <= '0;
            drop      <= flush_drop;
        end else begin
            if (do_alloc) begin
                pc_mem[alloc_idx] <= i_pc;
                filled[alloc_idx] <= 1'b0;
                alloc_ptr         <= alloc_ptr + ONE;
            end
            if (do_fill) begin
                data_mem[fill_idx] <= i_mem_rsp_data;
                filled[fill_idx]   <= 1'b1;
                fill_ptr           <= fill_ptr + ONE;
            end
            if (do_drop) begin
                drop <= drop - ONE;
            end
            if (do_pop) begin
                head_ptr <= head_ptr + ONE;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a table of request-path vectors checked from reset, then hand-written sequences.
// A memory model and an expected queue check everything the queue hands to decode.
module tb_fetch_queue;
    logic        i_clk = 1'b0;
    logic        i_rst, i_pc_valid, i_mem_req_ready, i_mem_rsp_valid, i_inst_ready, i_flush;
    logic [31:0] i_pc, i_mem_rsp_data;
    logic        o_pc_ready, o_mem_req_valid, o_inst_valid;
    logic [31:0] o_mem_req_addr, o_inst, o_inst_pc;

    fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_pc_valid(i_pc_valid), .i_pc(i_pc), .o_pc_ready(o_pc_ready),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
        .i_mem_req_ready(i_mem_req_ready),
        .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_inst_ready(i_inst_ready), .i_flush(i_flush)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        pc_valid;
        logic        req_ready;
        logic        flush;
        logic [31:0] pc;
        logic        exp_req_valid;
        logic        exp_pc_ready;
    } vec_t;
    vec_t vecs [8];

    logic [63:0] exp_q [$];
    logic [31:0] req_q [$];
    int n_cmp = 0, n_fail = 0, n_req = 0, n_pop = 0, stale = 0;
    logic last_valid, last_pc_ready, last_fire;
    logic [31:0] next_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h0000_0013 + (pc >> 2) * 32'h0010_0080;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_pc_valid = 1'b0; i_pc = '0; i_mem_req_ready = 1'b1;
        i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0; i_inst_ready = 1'b0; i_flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        exp_q.delete(); req_q.delete();
        stale = 0; n_req = 0; n_pop = 0;
    endtask

    // One clock: drive the response, sample outputs, model memory and decode, then advance.
    task automatic tick(input logic rsp);
        logic [63:0] e;
        i_mem_rsp_valid = rsp;
        i_mem_rsp_data  = 32'hdead_beef;
        if (rsp && !i_flush && stale == 0 && req_q.size() > 0) i_mem_rsp_data = inst_of(req_q[0]);
        #1;
        last_valid    = o_inst_valid;
        last_pc_ready = o_pc_ready;
        last_fire     = o_mem_req_valid && i_mem_req_ready;
        if (i_flush) begin
            chk("flush_blocks_output", o_inst_valid, 0);
            chk("flush_blocks_req", {o_mem_req_valid, o_pc_ready}, 0);
        end else if (o_inst_valid && i_inst_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_inst: got pc %0h required no output", o_inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", o_inst_pc, e[63:32]);
                chk("inst_data", o_inst, e[31:0]);
                n_pop++;
            end
        end
        if (i_flush) begin
            stale = stale + req_q.size();
            if (rsp && stale > 0) stale--;
            req_q.delete(); exp_q.delete();
        end else if (rsp) begin
            if (stale > 0) stale--;
            else if (req_q.size() > 0) exp_q.push_back({req_q.pop_front(), i_mem_rsp_data});
        end
        if (last_fire) begin
            chk("req_addr", o_mem_req_addr, i_pc);
            req_q.push_back(i_pc);
            n_req++;
        end
        @(posedge i_clk); #1;
        i_mem_rsp_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) vecs[i].pc = 32'($urandom_range(0, 32'h000f_ffff)) << 2;

        do_reset();
        chk("rst_inst_valid", o_inst_valid, 0);
        chk("rst_inst", o_inst, 0);
        chk("rst_inst_pc", o_inst_pc, 0);
        chk("rst_used", dut.used, 0);
        chk("rst_drop", dut.drop, 0);

        // Request path from reset, applied between edges so nothing is allocated.
        for (int i = 0; i < 8; i++) begin
            i_pc_valid = vecs[i].pc_valid; i_mem_req_ready = vecs[i].req_ready;
            i_flush = vecs[i].flush; i_pc = vecs[i].pc;
            #1;
            chk($sformatf("vec%0d_req_valid", i), o_mem_req_valid, vecs[i].exp_req_valid);
            chk($sformatf("vec%0d_pc_ready", i), o_pc_ready, vecs[i].exp_pc_ready);
            chk($sformatf("vec%0d_req_addr", i), o_mem_req_addr, vecs[i].pc);
            idle_inputs();
            @(posedge i_clk); #1;
        end
        chk("vec_no_alloc", dut.used, 0);

        // Streaming: responses one cycle after each request, decode always ready.
        do_reset();
        i_inst_ready = 1'b1; next_pc = 0;
        for (int c = 0; c < 6; c++) begin
            i_pc_valid = (next_pc < 32'hc); i_pc = next_pc;
            tick(req_q.size() > 0);
            if (last_fire) next_pc += 4;
            if (c == 1) chk("stream_no_bypass", last_valid, 0);
            if (c == 2) chk("stream_latency", last_valid, 1);
        end
        chk("stream_pops", n_pop, 3);
        chk("stream_drained", exp_q.size(), 0);

        // Backpressure: decode stalled until the queue fills.
        do_reset();
        i_pc_valid = 1'b1; next_pc = 0;
        for (int c = 0; c < 8; c++) begin
            i_pc = next_pc;
            tick(req_q.size() > 0);
            if (last_fire) next_pc += 4;
        end
        chk("bp_req_count", n_req, 4);
        chk("bp_full_pc_ready", last_pc_ready, 0);
        chk("bp_head_pc", o_inst_pc, 0);
        i_inst_ready = 1'b1; i_pc = next_pc;
        tick(1'b0);
        chk("bp_pop_no_free", last_pc_ready, 0);
        chk("bp_one_pop", n_pop, 1);
        i_inst_ready = 1'b0;
        tick(1'b0);
        chk("bp_ready_again", last_pc_ready, 1);
        chk("bp_req_0x10", req_q.size() > 0 ? req_q[req_q.size()-1] : 32'hffff_ffff, 32'h10);
        i_pc_valid = 1'b0; i_inst_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick(req_q.size() > 0);
        chk("bp_pops", n_pop, 5);
        chk("bp_drained", exp_q.size(), 0);

        // Flush with three requests in flight, then refetch from 0x100 within the remaining credit.
        do_reset();
        i_inst_ready = 1'b1; i_pc_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_pc = 32'(c * 4);
            tick(1'b0);
        end
        i_flush = 1'b1; i_pc = 32'h100;
        tick(1'b0);
        i_flush = 1'b0;
        chk("fl_drop3", dut.drop, 3);
        chk("fl_used0", dut.used, 0);
        tick(1'b0);
        chk("fl_accept_0x100", last_fire, 1);
        i_pc = 32'h104;
        tick(1'b0);
        chk("fl_credit_full", last_pc_ready, 0);
        i_pc_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick(1'b1);
        chk("fl_stale_hidden", n_pop, 0);
        tick(1'b1);
        tick(1'b0);
        chk("fl_first_pop", n_pop, 1);
        chk("fl_drained", exp_q.size(), 0);
        chk("fl_drop0", dut.drop, 0);

        // Flush in the same cycle as a response, then a response with nothing owed.
        do_reset();
        i_inst_ready = 1'b1; i_pc_valid = 1'b1;
        i_pc = 32'h0; tick(1'b0);
        i_pc = 32'h4; tick(1'b0);
        i_pc_valid = 1'b0; i_flush = 1'b1;
        tick(1'b1);
        i_flush = 1'b0;
        chk("fc_drop1", dut.drop, 1);
        tick(1'b1);
        chk("fc_drop0", dut.drop, 0);
        tick(1'b0);
        chk("fc_no_output", last_valid, 0);
        tick(1'b1);
        tick(1'b0);
        chk("proto_err_valid", o_inst_valid, 0);
        chk("proto_err_used", dut.used, 0);
        chk("proto_err_drop", dut.drop, 0);
        chk("proto_err_fill", dut.inflight, 0);

        // Flush while the head is valid and decode is ready.
        do_reset();
        i_pc_valid = 1'b1; i_pc = 32'h40;
        tick(1'b0);
        i_pc_valid = 1'b0;
        tick(1'b1);
        tick(1'b0);
        chk("fh_valid", last_valid, 1);
        i_inst_ready = 1'b1; i_flush = 1'b1;
        tick(1'b0);
        i_flush = 1'b0; i_inst_ready = 1'b0;
        chk("fh_no_pop", n_pop, 0);
        chk("fh_used0", dut.used, 0);

        // Reset with two buffered entries and one in flight.
        do_reset();
        i_pc_valid = 1'b1;
        i_pc = 32'h0; tick(1'b0);
        i_pc = 32'h4; tick(1'b1);
        i_pc = 32'h8; tick(1'b1);
        i_pc_valid = 1'b0;
        tick(1'b0);
        chk("rm_used3", dut.used, 3);
        chk("rm_inflight1", dut.inflight, 1);
        do_reset();
        chk("rm_inst_valid", o_inst_valid, 0);
        chk("rm_used", dut.used, 0);
        chk("rm_drop", dut.drop, 0);
        chk("rm_inst", o_inst, 0);
        chk("rm_inst_pc", o_inst_pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Prefetch buffer directly downstream of the PC-generating instruction fetch stage.
- Accepts PCs from fetch, issues them as in-order requests to instruction memory, and buffers the returned words with their PCs.
- Presents the buffered instructions to decode over a valid/ready handshake.
- Flushes on redirect (branch/jump): drops buffered entries and discards stale in-flight responses; drives backpressure to fetch.

Parameters:
- DEPTH, 4, entries in queue and max outstanding+buffered requests; power of 2, >=2
- AW, 32, address/PC width
- DW, 32, instruction width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_pc_valid  in  1  fetch offers i_pc
- i_pc  in  AW  PC to fetch
- o_pc_ready  out  1  PC accepted this cycle (fetch advances only when high)
- o_mem_req_valid  out  1  memory request valid
- o_mem_req_addr  out  AW  memory request address (= i_pc)
- i_mem_req_ready  in  1  memory accepts request
- i_mem_rsp_valid  in  1  memory response valid, in request order, no backpressure
- i_mem_rsp_data  in  DW  response instruction word
- o_inst_valid  out  1  head instruction available to decode
- o_inst  out  DW  head instruction
- o_inst_pc  out  AW  PC of head instruction
- i_inst_ready  in  1  decode consumes head
- i_flush  in  1  redirect: discard all queued and in-flight work

Behaviour:
- State:
  - Circular storage of DEPTH entries {pc, data, filled}.
  - Pointers alloc, fill, head, each log2(DEPTH)+1 bits, wrapping.
  - drop counter, log2(DEPTH)+1 bits.
  - used = alloc - head (mod 2^(log2(DEPTH)+1)).
  - inflight = alloc - fill.
- credit_ok = (used + drop) < DEPTH, computed from registered state only. A same-cycle pop does not free a slot.
- Request path (combinational):
  - o_mem_req_valid = i_pc_valid & credit_ok & ~i_flush
  - o_mem_req_addr = i_pc
  - o_pc_ready = i_mem_req_ready & credit_ok & ~i_flush
- Allocate when o_mem_req_valid & i_mem_req_ready:
  - Write pc into entry[alloc], clear filled, alloc+1.
- Response path:
  - If drop>0: i_mem_rsp_valid decrements drop; data discarded.
  - Else: write data into entry[fill], set filled, fill+1.
  - i_mem_rsp_valid while inflight==0 and drop==0 is a protocol error: ignore it, never corrupt state.
- Output path:
  - o_inst_valid = (used>0) & entry[head].filled & ~i_flush
  - o_inst = entry[head].data
  - o_inst_pc = entry[head].pc
  - Pop on o_inst_valid & i_inst_ready: head+1.
- Latency: a response in cycle N is visible at o_inst_valid in cycle N+1. There is no rsp-to-output bypass.
- Flush, with priority over allocate, fill and pop in that cycle:
  - Next state: alloc=fill=head=0, all filled cleared.
  - drop <= drop + inflight - (i_mem_rsp_valid ? 1 : 0).
  - A response arriving in the flush cycle is discarded and counted against the stale responses.
- Back-to-back flushes accumulate correctly in drop.
- While drop>0 the queue accepts new requests only within credit. The first non-dropped response fills entry 0.
- Full: used+drop==DEPTH forces o_pc_ready=0 and o_mem_req_valid=0.
- Empty: used==0 forces o_inst_valid=0.
- Simultaneous allocate, fill and pop in one cycle are all legal and independent.
- Reset:
  - Pointers and drop go to 0, all filled bits clear.
  - o_inst_valid=0. o_mem_req_valid and o_pc_ready follow i_pc_valid and i_mem_req_ready with credit_ok=1.
  - o_inst and o_inst_pc are 0 after reset (storage cleared).
  - Reset mid-operation abandons in-flight responses without counting them. The system resets memory on the same i_rst.

Test Plan:
- Streaming:
  - Stimulus: i_pc_valid=1 with PCs 0x0,0x4,0x8; memory ready; rsp returns 0x00000013,0x00100093,0x00200113 one cycle after each request; i_inst_ready=1.
  - Response: o_inst/o_inst_pc pairs appear in order, each one cycle after its response.
- Backpressure:
  - Stimulus: i_inst_ready=0, DEPTH=4, memory ready, immediate responses.
  - Response: exactly 4 requests issued (PCs 0x0..0xC), then o_pc_ready=0. Raising i_inst_ready for 1 cycle pops 0x0, and o_pc_ready returns high the following cycle.
- Flush with in-flight:
  - Stimulus: 3 requests outstanding with no responses, then assert i_flush. Memory then returns 3 stale words, then the response for new PC 0x100.
  - Response: no o_inst_valid for the stale words. The first o_inst_pc after flush is 0x100.
- Flush coincident with response:
  - Stimulus: 2 in flight; i_flush and i_mem_rsp_valid in the same cycle.
  - Response: drop==1, exactly one further response discarded.
- Flush with valid head:
  - Stimulus: i_flush while o_inst_valid would be 1 and i_inst_ready=1.
  - Response: o_inst_valid=0 that cycle, no pop; next cycle used==0.
- Reset mid-stream:
  - Stimulus: assert i_rst with 2 buffered entries and 1 in flight.
  - Response: next cycle o_inst_valid=0, used==0, drop==0, o_inst=0, o_inst_pc=0.
